// File: rtl/switch_output_arbiter.sv
// Wormhole round-robin output arbiter: grants one input buffer per packet.
// Define OUTPUT_ARBITER_WATCHDOG_EN to abort packets stalled for 255 cycles.
module switch_output_arbiter #(
    parameter int NUM_BUFFERS = 4,
    parameter int LEN_W       = 8
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic [NUM_BUFFERS-1:0]           req,
    input  logic [NUM_BUFFERS-1:0]           empty,
    input  logic [NUM_BUFFERS*LEN_W-1:0]     pkt_len,
    input  logic                             out_ready,
    output logic [NUM_BUFFERS-1:0]           REN,
    output logic [$clog2(NUM_BUFFERS)-1:0]   sel,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             pkt_done,
    output logic                             timeout
);

    localparam int SEL_W = $clog2(NUM_BUFFERS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_BUFFERS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               found;
    logic [SEL_W-1:0]   grant_idx;
    logic [LEN_W-1:0]   grant_len;
    logic [SEL_W-1:0]   next_ptr;
    logic               fire;
    logic               wd_fire;
    int                 idx;

    // Rotating priority scan starting at rr_ptr
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_BUFFERS) idx = idx - NUM_BUFFERS;
            if (!found && req[SEL_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        grant_len = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (SEL_W'(i) == grant_idx) grant_len = pkt_len[i*LEN_W +: LEN_W];
        end
    end

    assign next_ptr = (sel_q == LAST) ? '0 : sel_q + 1'b1;

`ifdef OUTPUT_ARBITER_WATCHDOG_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;

    // Fires in the 255th consecutive stalled cycle; the counter never holds 255
    always_comb begin
        stall_cnt_d = '0;
        wd_fire     = 1'b0;
        if (state_q == STREAM && empty[sel_q]) begin
            if (stall_cnt_q == 8'd254) wd_fire = 1'b1;
            else stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        remaining_d = remaining_q;
        rr_ptr_d    = rr_ptr_q;
        REN         = '0;
        out_valid   = 1'b0;
        pkt_done    = 1'b0;
        fire        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d       = grant_idx;
                    remaining_d = (grant_len == '0) ? LEN_W'(1) : grant_len;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                out_valid  = !empty[sel_q];
                fire       = out_valid & out_ready;
                REN[sel_q] = fire;
                if (fire) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        pkt_done = 1'b1;
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end else if (wd_fire) begin
                    remaining_d = '0;
                    rr_ptr_d    = next_ptr;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            remaining_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            remaining_q <= remaining_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign sel     = sel_q;
    assign busy    = (state_q == STREAM);
    assign timeout = wd_fire;

endmodule
